// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding an
// in-order instruction queue, with decode-stage redirect flushing.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [4:0]  q_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [4:0]  FULL     = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   code_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [4:0]    count_next;
  logic [1:0]    unused_pc_bits;

  assign unused_pc_bits = redirect_pc[1:0];

  assign imem_addr  = fetch_pc;
  assign inst_valid = (q_count != '0);
  assign inst_code  = code_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];

  always_comb begin
    pop        = 1'b0;
    push       = 1'b0;
    count_next = q_count;
    pop        = inst_valid && inst_ready;
    push       = (state == WAIT) && imem_rvalid;
    count_next = q_count + 5'(push) - 5'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      imem_req <= 1'b0;
      fetch_pc <= START_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      code_mem <= '{default: '0};
      pc_mem   <= '{default: '0};
    end else if (redirect) begin
      // Flush wins over any push/pop/grant; a granted or pending response
      // is left to drain through DROP.
      q_count  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      imem_req <= 1'b0;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      case (state)
        REQ:     state <= imem_gnt ? DROP : IDLE;
        WAIT:    state <= imem_rvalid ? IDLE : DROP;
        default: state <= state;
      endcase
    end else begin
      if (push) begin
        code_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      q_count <= count_next;

      case (state)
        IDLE: begin
          if (q_count < FULL) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (count_next < FULL) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based
// reference model of the fetch unit.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [4:0]  q_count;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_code(inst_code), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .q_count(q_count)
  );

  typedef enum int {M_IDLE, M_REQ, M_WAIT, M_DROP} m_state_t;

  int          vectors = 0;
  int          miscompares = 0;
  m_state_t    m_state;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  logic [63:0] m_q[$];
  logic [31:0] exp_stream;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state    = M_IDLE;
    m_fetch_pc = {RESET_PC[31:2], 2'b00};
    m_req_pc   = '0;
    m_q.delete();
  endtask

  task automatic m_step(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdr, input logic [31:0] rpc, input logic rdy);
    int n0;
    n0 = m_q.size();
    if (rdr) begin
      m_q.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
      if (m_state == M_REQ)       m_state = g  ? M_DROP : M_IDLE;
      else if (m_state == M_WAIT) m_state = rv ? M_IDLE : M_DROP;
    end else begin
      if (n0 != 0 && rdy) void'(m_q.pop_front());
      case (m_state)
        M_IDLE: if (n0 < DEPTH) m_state = M_REQ;
        M_REQ:  if (g) begin
                  m_req_pc   = m_fetch_pc;
                  m_fetch_pc = m_fetch_pc + 32'd4;
                  m_state    = M_WAIT;
                end
        M_WAIT: if (rv) begin
                  m_q.push_back({rd, m_req_pc});
                  m_state = (m_q.size() < DEPTH) ? M_REQ : M_IDLE;
                end
        M_DROP: if (rv) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    check32("imem_req", 32'(imem_req), 32'(m_state == M_REQ));
    if (m_state == M_REQ) check32("imem_addr", imem_addr, m_fetch_pc);
    check32("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    check32("q_count", 32'(q_count), 32'(m_q.size()));
    if (m_q.size() != 0) begin
      check32("inst_code", inst_code, m_q[0][63:32]);
      check32("inst_pc", inst_pc, m_q[0][31:0]);
    end
  endtask

  // Called just after a falling edge: drive one cycle of inputs, advance the
  // model, then compare after the next falling edge.
  task automatic tick(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdr, input logic [31:0] rpc, input logic rdy);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    inst_ready  = rdy;
    m_step(g, rv, rd, rdr, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Same as tick, but also checks the popped head against a contiguous
  // address stream.
  task automatic tick_s(input logic g, input logic rv, input logic rdy);
    if (m_q.size() != 0 && rdy) begin
      check32("stream_pc", inst_pc, exp_stream);
      exp_stream = exp_stream + 32'd4;
    end
    tick(g, rv, $urandom, 1'b0, '0, rdy);
  endtask

  function automatic logic resp_pending();
    return (m_state == M_WAIT) || (m_state == M_DROP);
  endfunction

  initial begin
    rst = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect = 0; redirect_pc = '0; inst_ready = 0;
    m_reset();
    @(negedge clk); @(negedge clk);
    check32("rst_imem_req", 32'(imem_req), 32'd0);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst_code", inst_code, 32'd0);
    check32("rst_inst_pc", inst_pc, 32'd0);
    check32("rst_q_count", 32'(q_count), 32'd0);
    rst = 1'b0;
    compare_all();

    // First request after reset release
    tick(0, 0, '0, 0, '0, 1);
    check32("first_req", 32'(imem_req), 32'd1);
    check32("first_addr", imem_addr, RESET_PC);

    // Streaming: grant always, response one cycle after grant, consumer ready
    exp_stream = RESET_PC;
    for (int i = 0; i < 40; i++) tick_s(1, m_state == M_WAIT, 1);
    check32("stream_progress", 32'(exp_stream >= 32'h40), 32'd1);

    // Fill to full with consumer stalled
    tick(1, m_state == M_WAIT, $urandom, 1, 32'h0, 0);
    for (int i = 0; i < 24; i++) tick(1, resp_pending(), $urandom, 0, '0, 0);
    check32("full_q_count", 32'(q_count), 32'd4);
    check32("full_no_req", 32'(imem_req), 32'd0);
    check32("full_head_pc", inst_pc, 32'h0);
    begin
      int i;
      for (i = 0; i < 10; i++) begin
        if (m_state == M_REQ) break;
        tick(1, 0, '0, 0, '0, 1);
      end
      check32("resume_reached", 32'(m_state == M_REQ), 32'd1);
      check32("resume_addr", imem_addr, 32'h10);
    end

    // Redirect while waiting without response
    for (int i = 0; i < 10; i++) begin
      if (m_state == M_REQ) break;
      tick(0, resp_pending(), $urandom, 0, '0, 1);
    end
    tick(1, 0, '0, 0, '0, 1);
    tick(0, 0, '0, 1, 32'h0000_0103, 1);
    check32("flush_q_count", 32'(q_count), 32'd0);
    tick(0, 1, 32'hDEAD_BEEF, 0, '0, 1);
    check32("drop_no_push", 32'(inst_valid), 32'd0);
    tick(0, 0, '0, 0, '0, 1);
    check32("redir_req", 32'(imem_req), 32'd1);
    check32("redir_addr", imem_addr, 32'h100);

    // Redirect in the same cycle as a grant
    tick(1, 0, '0, 1, 32'h0000_0200, 1);
    tick(0, 1, 32'hBAD0_0001, 0, '0, 1);
    tick(0, 0, '0, 0, '0, 1);
    check32("gnt_redir_addr", imem_addr, 32'h200);
    check32("gnt_redir_q", 32'(q_count), 32'd0);

    // Simultaneous push and pop at two entries, then a long drain
    exp_stream = 32'h200;
    for (int i = 0; i < 20; i++) begin
      if (m_state == M_WAIT && m_q.size() == 2) break;
      tick_s(1, m_state == M_WAIT && m_q.size() < 2, 0);
    end
    check32("pushpop_setup", 32'(m_state == M_WAIT && m_q.size() == 2), 32'd1);
    tick_s(1, 1, 1);
    check32("pushpop_q_count", 32'(q_count), 32'd2);
    for (int i = 0; i < 45; i++) tick_s(1, m_state == M_WAIT, 1);
    check32("drain_pops", 32'(exp_stream >= 32'h250), 32'd1);

    // Reset while waiting with three entries queued
    for (int i = 0; i < 30; i++) begin
      if (m_state == M_WAIT && m_q.size() == 3) break;
      tick(1, resp_pending() && m_q.size() < 3, $urandom, 0, '0, 0);
    end
    check32("rst_setup", 32'(m_state == M_WAIT && m_q.size() == 3), 32'd1);
    #2 rst = 1'b1;
    #1;
    check32("async_imem_req", 32'(imem_req), 32'd0);
    check32("async_inst_valid", 32'(inst_valid), 32'd0);
    check32("async_q_count", 32'(q_count), 32'd0);
    check32("async_inst_code", inst_code, 32'd0);
    check32("async_inst_pc", inst_pc, 32'd0);
    imem_gnt = 0; imem_rvalid = 0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    compare_all();
    tick(0, 1, 32'h5151_5151, 0, '0, 1);
    check32("stale_q_count", 32'(q_count), 32'd0);
    check32("restart_req", 32'(imem_req), 32'd1);
    check32("restart_addr", imem_addr, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic g, rv, rdr, rdy;
      g   = ($urandom_range(0, 9) < 7);
      rv  = resp_pending() && ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 6);
      rdr = ($urandom_range(0, 19) == 0) && !(m_state == M_DROP && rv);
      tick(g, rv, $urandom, rdr, $urandom, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
